linear_layer_start_fifo_srl: RTL



---
 rtl/linear_layer_start_fifo_srl.sv | 102 ++++++++++
 1 files changed

// File: rtl/linear_layer_start_fifo_srl.sv
// Start-token FIFO around an inline shift-register store: tracks the head pointer and flags.
// Define LINEAR_START_FIFO_LEVEL_EN to add the registered occupancy output if_num_data_valid.
module linear_layer_start_fifo_srl #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned ADDR_WIDTH = 1,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
`ifdef LINEAR_START_FIFO_LEVEL_EN
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
`endif
  output logic [DATA_WIDTH-1:0] if_dout
);

  localparam int unsigned PtrW = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic                  full_n_q, full_n_d;
  logic                  empty_n_q, empty_n_d;
  logic                  push, pop;

  assign push = if_write & if_write_ce & full_n_q;
  assign pop  = if_read & if_read_ce & empty_n_q;

  always_comb begin
    ptr_d     = ptr_q;
    full_n_d  = full_n_q;
    empty_n_d = empty_n_q;
    if (push && !pop) begin
      ptr_d     = ptr_q + PtrW'(1);
      empty_n_d = 1'b1;
      if (ptr_q == PtrW'(DEPTH - 2)) full_n_d = 1'b0;
    end else if (pop && !push) begin
      ptr_d    = ptr_q - PtrW'(1);
      full_n_d = 1'b1;
      if (ptr_q == '0) empty_n_d = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ptr_q     <= '1;
      full_n_q  <= 1'b1;
      empty_n_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      full_n_q  <= full_n_d;
      empty_n_q <= empty_n_d;
    end
  end

  // Storage carries no reset; emptiness is tracked solely by ptr/empty_n.
  always_ff @(posedge ap_clk) begin
    if (push) begin
      mem_q[0] <= if_din;
      for (int i = 1; i < int'(DEPTH); i++) mem_q[i] <= mem_q[i-1];
    end
  end

  always_comb begin
    if_dout = '0;
    if (empty_n_q) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (ptr_q[ADDR_WIDTH-1:0] == ADDR_WIDTH'(i)) if_dout = mem_q[i];
      end
    end
  end

  assign if_full_n  = full_n_q;
  assign if_empty_n = empty_n_q;

`ifdef LINEAR_START_FIFO_LEVEL_EN
  logic [ADDR_WIDTH:0] level_q, level_d;

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + PtrW'(1);
    else if (pop && !push) level_d = level_q - PtrW'(1);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) level_q <= '0;
    else           level_q <= level_d;
  end

  assign if_num_data_valid = level_q;
`endif

  // Legal pointer range is -1 (empty) through DEPTH-1 (full).
  ptr_range_a: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    (int'($signed(ptr_q)) >= -1) && (int'($signed(ptr_q)) <= int'(DEPTH) - 1));

endmodule
